// File: rtl/rom_rs_pkg.sv
// rom_rs_pkg: shared motion-estimation memory sizes and address widths
package rom_rs_pkg;
  localparam int RMEM_MAX = 256;
  localparam int SMEM_MAX = 1024;
  localparam int DATA_W   = 8;
  localparam int AR_W     = 8;
  localparam int AS_W     = 10;
endpackage

// File: rtl/rom_rs.sv
// rom_rs: reference (1 read port) and search (2 read ports) pixel memories with registered reads
module rom_rs
  import rom_rs_pkg::*;
#(
  parameter int RMEM_MAX = rom_rs_pkg::RMEM_MAX,
  parameter int SMEM_MAX = rom_rs_pkg::SMEM_MAX,
  parameter int DATA_W   = rom_rs_pkg::DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [AR_W-1:0]   AddressR,
  output logic [DATA_W-1:0] R,
  input  logic [AS_W-1:0]   AddressS1,
  input  logic [AS_W-1:0]   AddressS2,
  output logic [DATA_W-1:0] S1,
  output logic [DATA_W-1:0] S2,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic [AS_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0] wr_data
);
  logic [DATA_W-1:0] Rmem [RMEM_MAX] = '{default: '0};
  logic [DATA_W-1:0] Smem [SMEM_MAX] = '{default: '0};
  logic w_r_we;
  assign w_r_we = wr_en && !wr_sel && (wr_addr < AS_W'(RMEM_MAX));
  // Contents are never cleared by reset; reset only zeroes the read registers and blocks writes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      R  <= '0;
      S1 <= '0;
      S2 <= '0;
    end else begin
      R  <= Rmem[AddressR];
      S1 <= Smem[AddressS1];
      S2 <= Smem[AddressS2];
      if (w_r_we) Rmem[wr_addr[AR_W-1:0]] <= wr_data;
      if (wr_en && wr_sel) Smem[wr_addr] <= wr_data;
    end
  end
endmodule

// File: tb/tb_rom_rs.sv
// tb_rom_rs: directed + random checks of rom_rs against an array reference model
module tb_rom_rs;
  logic       clock = 0;
  logic       reset = 0;
  logic [7:0] AddressR = 0;
  logic [9:0] AddressS1 = 0, AddressS2 = 0;
  logic [7:0] R, S1, S2;
  logic       wr_en = 0, wr_sel = 0;
  logic [9:0] wr_addr = 0;
  logic [7:0] wr_data = 0;
  int checks = 0, passes = 0;
  logic [7:0] ref_r [256];
  logic [7:0] ref_s [1024];

  rom_rs dut (
    .clock(clock), .reset(reset), .AddressR(AddressR), .R(R),
    .AddressS1(AddressS1), .AddressS2(AddressS2), .S1(S1), .S2(S2),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One clock: expected read data is taken from the model before the write lands (read-first).
  task automatic step(input string tag);
    logic [7:0] er, e1, e2;
    er = ref_r[AddressR];
    e1 = ref_s[AddressS1];
    e2 = ref_s[AddressS2];
    if (wr_en && !reset) begin
      if (wr_sel) ref_s[wr_addr] = wr_data;
      else if (wr_addr < 256) ref_r[wr_addr[7:0]] = wr_data;
    end
    @(posedge clock); #1;
    chk({tag, "_R"}, R, er);
    chk({tag, "_S1"}, S1, e1);
    chk({tag, "_S2"}, S2, e2);
  endtask

  initial begin
    foreach (ref_r[i]) ref_r[i] = 0;
    foreach (ref_s[i]) ref_s[i] = 0;
    #1 reset = 1;
    #1;
    chk("rst_R", R, 8'h00);
    chk("rst_S1", S1, 8'h00);
    chk("rst_S2", S2, 8'h00);
    wr_en = 1; wr_sel = 0; wr_addr = 10'd5; wr_data = 8'h77;
    @(posedge clock); #1;
    wr_sel = 1;
    @(posedge clock); #1;
    wr_en = 0;
    reset = 0;
    for (int i = 0; i < 1024; i++) begin
      AddressR = 8'(i); AddressS1 = 10'(i); AddressS2 = 10'(1023 - i);
      step("powerup");
    end
    for (int i = 0; i < 256; i++) begin
      wr_en = 1; wr_sel = 0; wr_addr = 10'(i); wr_data = 8'(i);
      step("loadR");
    end
    wr_en = 0; AddressR = 8'h5A;
    step("rd5A");
    @(posedge clock); #1;
    chk("R_5A", R, 8'h5A);
    for (int i = 0; i < 1024; i++) begin
      wr_en = 1; wr_sel = 1; wr_addr = 10'(i); wr_data = 8'(i % 256);
      step("loadS");
    end
    wr_en = 0; AddressS1 = 10'd960; AddressS2 = 10'd31;
    step("rdS");
    chk("S1_960", S1, 8'hC0);
    chk("S2_31", S2, 8'h1F);
    wr_en = 1; wr_sel = 1; wr_addr = 10'd100; wr_data = 8'hAB; AddressS1 = 10'd100;
    step("rfirst");
    chk("S1_old", S1, 8'h64);
    wr_en = 0;
    step("rnext");
    chk("S1_new", S1, 8'hAB);
    wr_en = 1; wr_sel = 0; wr_addr = 10'd300; wr_data = 8'hEE;
    step("oob");
    wr_en = 0; AddressR = 8'd44; AddressS1 = 10'd300; AddressS2 = 10'd44;
    step("oob_rd");
    chk("oob_S300", S1, 8'h2C);
    chk("oob_R44", R, 8'h2C);
    AddressR = 8'h5A;
    step("pre_rst");
    reset = 1;
    #1;
    chk("async_R", R, 8'h00);
    chk("async_S1", S1, 8'h00);
    chk("async_S2", S2, 8'h00);
    wr_en = 1; wr_sel = 0; wr_addr = 10'h05A; wr_data = 8'h00;
    @(posedge clock); #1;
    chk("hold_R", R, 8'h00);
    wr_en = 0; reset = 0;
    step("post_rst");
    chk("kept_5A", R, 8'h5A);
    for (int i = 0; i < 400; i++) begin
      wr_en = 1'($urandom); wr_sel = 1'($urandom); wr_addr = 10'($urandom);
      wr_data = 8'($urandom); AddressR = 8'($urandom);
      AddressS1 = 10'($urandom); AddressS2 = ($urandom_range(0, 3) == 0) ? AddressS1 : 10'($urandom);
      if ($urandom_range(0, 3) == 0) AddressR = wr_addr[7:0];
      step("rand");
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
